// File: rtl/mem_phase_controller_pkg.sv
// Shared phase encoding and width defaults for the memory phase controller.
// CPU/UART debug decoders import this so phase numbers stay consistent.
package mem_phase_controller_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 16;
  localparam int DRAIN_CYCLES_DEF = 2;
  localparam int TIMEOUT_W_DEF    = 24;

  typedef logic [2:0] phase_t;

  localparam logic [2:0] PH_LOAD  = 3'd0;
  localparam logic [2:0] PH_START = 3'd1;
  localparam logic [2:0] PH_RUN   = 3'd2;
  localparam logic [2:0] PH_DRAIN = 3'd3;
  localparam logic [2:0] PH_DUMP  = 3'd4;
  localparam logic [2:0] PH_DONE  = 3'd5;

endpackage

// File: rtl/mem_phase_controller_if.sv
// Bus bundle between the phase controller and the CPU/UART/RAM side.
// The master modport is the controller (it owns the RAM port).
interface mem_phase_controller_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              uart_load_done;
  logic              cpu_end;
  logic [ADDR_W-1:0] uart_addr;
  logic [DATA_W-1:0] uart_wdata;
  logic              uart_we;
  logic              uart_rd_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic [DATA_W-1:0] cpu_rdata;
  logic [DATA_W-1:0] uart_rdata;
  logic              uart_rd_valid;
  logic              cpu_run;
  logic              cpu_start;
  logic [2:0]        phase;
  logic              timeout;

  modport master (
    input  uart_load_done, cpu_end, uart_addr, uart_wdata, uart_we, uart_rd_req,
    input  cpu_addr, cpu_wdata, cpu_we, ram_rdata,
    output ram_addr, ram_wdata, ram_we, cpu_rdata, uart_rdata, uart_rd_valid,
    output cpu_run, cpu_start, phase, timeout
  );

  modport slave (
    output uart_load_done, cpu_end, uart_addr, uart_wdata, uart_we, uart_rd_req,
    output cpu_addr, cpu_wdata, cpu_we, ram_rdata,
    input  ram_addr, ram_wdata, ram_we, cpu_rdata, uart_rdata, uart_rd_valid,
    input  cpu_run, cpu_start, phase, timeout
  );

endinterface

// File: rtl/mem_phase_controller_phase_watchdog.sv
// Saturating RUN-phase watchdog: clear dominates, counts while enabled,
// and sticks at all-ones where expired is raised.
module phase_watchdog #(
  parameter int TIMEOUT_W = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  assign expired = &cnt_q;

  // next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !expired) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_phase_controller.sv
// Single-port RAM arbiter and system phase sequencer (LOAD/START/RUN/DRAIN/DUMP/DONE).
// Interface widths must match ADDR_W/DATA_W.
module mem_phase_controller
  import mem_phase_controller_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int TIMEOUT_W    = TIMEOUT_W_DEF,
  parameter int WDOG_EN      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_phase_controller_if.master bus
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

  phase_t            phase_q, phase_d;
  logic              ld_q;
  logic              timeout_q, timeout_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0] uart_rdata_q, uart_rdata_d;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic              ram_we_s;
  logic              wd_expired_s;
  logic              ld_rise_s, ld_fall_s;

  assign ld_rise_s = bus.uart_load_done && !ld_q;
  assign ld_fall_s = !bus.uart_load_done && ld_q;

  phase_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (phase_q != PH_RUN),
    .en      (phase_q == PH_RUN),
    .expired (wd_expired_s)
  );

  // RAM port owner mux; reset suppresses any write already on the bus
  always_comb begin
    ram_addr_s  = addr_q;
    ram_wdata_s = wdata_q;
    ram_we_s    = 1'b0;
    if (reset) begin
      ram_addr_s  = '0;
      ram_wdata_s = '0;
      ram_we_s    = 1'b0;
    end else begin
      case (phase_q)
        PH_LOAD: begin
          ram_addr_s  = bus.uart_addr;
          ram_wdata_s = bus.uart_wdata;
          ram_we_s    = bus.uart_we;
        end
        PH_RUN: begin
          ram_addr_s  = bus.cpu_addr;
          ram_wdata_s = bus.cpu_wdata;
          ram_we_s    = bus.cpu_we;
        end
        PH_DUMP: begin
          ram_addr_s  = bus.uart_addr;
        end
        default: begin
          ram_we_s    = 1'b0;
        end
      endcase
    end
  end

  // phase sequencing, drain timing and watchdog abort
  always_comb begin
    phase_d   = phase_q;
    timeout_d = timeout_q;
    drain_d   = drain_q;
    case (phase_q)
      PH_LOAD: begin
        if (ld_rise_s) begin
          phase_d = PH_START;
        end else begin
          phase_d = PH_LOAD;
        end
      end
      PH_START: begin
        phase_d = PH_RUN;
      end
      PH_RUN: begin
        // cpu_end outranks a simultaneous watchdog expiry
        if (bus.cpu_end) begin
          phase_d = PH_DRAIN;
          drain_d = '0;
        end else if ((WDOG_EN != 0) && wd_expired_s) begin
          phase_d   = PH_DRAIN;
          drain_d   = '0;
          timeout_d = 1'b1;
        end else begin
          phase_d = PH_RUN;
        end
      end
      PH_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          phase_d = PH_DUMP;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      PH_DUMP: begin
        if (ld_fall_s) begin
          phase_d = PH_DONE;
        end else begin
          phase_d = PH_DUMP;
        end
      end
      PH_DONE: begin
        phase_d = PH_DONE;
      end
      default: begin
        phase_d = PH_LOAD;
      end
    endcase
  end

  // dump read pipeline: valid one cycle after the request, data held afterwards
  always_comb begin
    rd_pend_d    = (phase_q == PH_DUMP) && bus.uart_rd_req;
    uart_rdata_d = rd_pend_q ? bus.ram_rdata : uart_rdata_q;
  end

  // state registers; load_done history is sampled during reset so a held level cannot fire
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= PH_LOAD;
      ld_q         <= bus.uart_load_done;
      timeout_q    <= 1'b0;
      drain_q      <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rd_pend_q    <= 1'b0;
      uart_rdata_q <= '0;
    end else begin
      phase_q      <= phase_d;
      ld_q         <= bus.uart_load_done;
      timeout_q    <= timeout_d;
      drain_q      <= drain_d;
      addr_q       <= ram_addr_s;
      wdata_q      <= ram_wdata_s;
      rd_pend_q    <= rd_pend_d;
      uart_rdata_q <= uart_rdata_d;
    end
  end

  assign bus.ram_addr      = ram_addr_s;
  assign bus.ram_wdata     = ram_wdata_s;
  assign bus.ram_we        = ram_we_s;
  assign bus.cpu_rdata     = ((phase_q == PH_RUN) && !reset) ? bus.ram_rdata : '0;
  assign bus.uart_rd_valid = rd_pend_q && !reset;
  assign bus.uart_rdata    = (rd_pend_q && !reset) ? bus.ram_rdata : uart_rdata_q;
  assign bus.cpu_run       = (phase_q == PH_RUN) && !reset;
  assign bus.cpu_start     = (phase_q == PH_START) && !reset;
  assign bus.phase         = phase_q;
  assign bus.timeout       = timeout_q;

endmodule

// File: tb/tb_mem_phase_controller.sv
// Directed bench for mem_phase_controller: a cycle table for the main flow
// plus hand sequences for watchdog, reset abort and load_done edge cases.
module tb_mem_phase_controller;
  import mem_phase_controller_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_phase_controller_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_phase_controller #(.TIMEOUT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: synchronous read returning pre-write contents
  logic [15:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct packed {
    logic        ld;
    logic        uwe;
    logic [15:0] uaddr;
    logic [15:0] udata;
    logic        urd;
    logic        cwe;
    logic [15:0] caddr;
    logic [15:0] cdata;
    logic        cend;
    logic [2:0]  e_phase;
    logic        e_we;
    logic [15:0] e_addr;
    logic [15:0] e_wdata;
    logic        e_start;
    logic        e_run;
    logic [15:0] e_crd;
    logic        e_valid;
    logic [15:0] e_urd;
  } vec_t;

  vec_t vecs [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs(input logic ld);
    bus.uart_load_done = ld;
    bus.cpu_end        = 1'b0;
    bus.uart_addr      = 16'h0000;
    bus.uart_wdata     = 16'h0000;
    bus.uart_we        = 1'b0;
    bus.uart_rd_req    = 1'b0;
    bus.cpu_addr       = 16'h0000;
    bus.cpu_wdata      = 16'h0000;
    bus.cpu_we         = 1'b0;
  endtask

  task automatic reset_dut(input logic ld);
    clear_inputs(ld);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    #1;
  endtask

  // LOAD -> START -> first RUN cycle observed on return
  task automatic start_run();
    reset_dut(1'b0);
    step();
    bus.uart_load_done = 1'b1;
    step();
    step();
  endtask

  initial begin
    int n;
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    bus.ram_rdata = 16'h0000;

    //            ld    uwe   uaddr     udata     urd   cwe   caddr     cdata     cend  ph    we    addr      wdata     st    run   crd       vld   urd
    vecs[0]  = '{1'b0, 1'b1, 16'h0010, 16'hABCD, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h0010, 16'hABCD, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b1, 16'h0011, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd0, 1'b1, 16'h0011, 16'h1234, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b1, 16'h0030, 16'h9999, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd1, 1'b0, 16'h0011, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b1, 16'h0030, 16'h9999, 1'b0, 1'b1, 16'h0020, 16'h5555, 1'b0, 3'd2, 1'b1, 16'h0020, 16'h5555, 1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 3'd2, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000};
    vecs[5]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 3'd2, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0000};
    vecs[6]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 3'd2, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0000};
    vecs[7]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 3'd2, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'hABCD, 1'b0, 16'h0000};
    vecs[8]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 3'd3, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0040, 16'h7777, 1'b0, 3'd3, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[10] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd4, 1'b0, 16'h0020, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000};
    vecs[11] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd4, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h5555};
    vecs[12] = '{1'b0, 1'b0, 16'h0011, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd4, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hABCD};
    vecs[13] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd5, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h1234};
    vecs[14] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 3'd5, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234};
    vecs[15] = '{1'b1, 1'b1, 16'h0010, 16'h0000, 1'b0, 1'b1, 16'h0010, 16'h0000, 1'b0, 3'd5, 1'b0, 16'h0011, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h1234};

    // reset state
    reset_dut(1'b0);
    chk("rst_phase", 32'(bus.phase), 32'(PH_LOAD));
    chk("rst_cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("rst_cpu_start", 32'(bus.cpu_start), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_rd_valid", 32'(bus.uart_rd_valid), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_uart_rdata", 32'(bus.uart_rdata), 32'd0);
    chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_wdata", 32'(bus.ram_wdata), 32'd0);

    // main flow, one table row per cycle
    for (int i = 0; i < 16; i++) begin
      bus.uart_load_done = vecs[i].ld;
      bus.uart_we        = vecs[i].uwe;
      bus.uart_addr      = vecs[i].uaddr;
      bus.uart_wdata     = vecs[i].udata;
      bus.uart_rd_req    = vecs[i].urd;
      bus.cpu_we         = vecs[i].cwe;
      bus.cpu_addr       = vecs[i].caddr;
      bus.cpu_wdata      = vecs[i].cdata;
      bus.cpu_end        = vecs[i].cend;
      #1;
      chk($sformatf("row%0d_phase", i), 32'(bus.phase), 32'(vecs[i].e_phase));
      chk($sformatf("row%0d_ram_we", i), 32'(bus.ram_we), 32'(vecs[i].e_we));
      chk($sformatf("row%0d_ram_addr", i), 32'(bus.ram_addr), 32'(vecs[i].e_addr));
      chk($sformatf("row%0d_ram_wdata", i), 32'(bus.ram_wdata), 32'(vecs[i].e_wdata));
      chk($sformatf("row%0d_cpu_start", i), 32'(bus.cpu_start), 32'(vecs[i].e_start));
      chk($sformatf("row%0d_cpu_run", i), 32'(bus.cpu_run), 32'(vecs[i].e_run));
      chk($sformatf("row%0d_cpu_rdata", i), 32'(bus.cpu_rdata), 32'(vecs[i].e_crd));
      chk($sformatf("row%0d_rd_valid", i), 32'(bus.uart_rd_valid), 32'(vecs[i].e_valid));
      chk($sformatf("row%0d_uart_rdata", i), 32'(bus.uart_rdata), 32'(vecs[i].e_urd));
      chk($sformatf("row%0d_timeout", i), 32'(bus.timeout), 32'd0);
      step();
    end
    chk("dropped_uart_write", 32'(mem[16'h0030]), 32'd0);
    chk("dropped_drain_write", 32'(mem[16'h0040]), 32'd0);

    // watchdog expiry: counter 0..15 across 16 RUN cycles, then DRAIN
    start_run();
    n = 0;
    while (bus.phase == PH_RUN && n < 40) begin
      n++;
      step();
    end
    chk("wdog_run_cycles", 32'(n), 32'd16);
    chk("wdog_phase", 32'(bus.phase), 32'(PH_DRAIN));
    chk("wdog_timeout", 32'(bus.timeout), 32'd1);
    chk("wdog_cpu_run", 32'(bus.cpu_run), 32'd0);
    repeat (2) step();
    chk("wdog_dump_phase", 32'(bus.phase), 32'(PH_DUMP));
    chk("wdog_timeout_sticky", 32'(bus.timeout), 32'd1);

    // cpu_end in the expiry cycle wins
    start_run();
    repeat (15) step();
    bus.cpu_end = 1'b1;
    #1;
    chk("tie_still_run", 32'(bus.phase), 32'(PH_RUN));
    step();
    bus.cpu_end = 1'b0;
    chk("tie_phase", 32'(bus.phase), 32'(PH_DRAIN));
    chk("tie_timeout", 32'(bus.timeout), 32'd0);

    // reset mid-RUN with a CPU write pending
    start_run();
    step();
    bus.cpu_we    = 1'b1;
    bus.cpu_addr  = 16'h0050;
    bus.cpu_wdata = 16'hBEEF;
    reset = 1'b1;
    #1;
    chk("rstrun_ram_we", 32'(bus.ram_we), 32'd0);
    step();
    reset = 1'b0;
    #1;
    chk("rstrun_phase", 32'(bus.phase), 32'(PH_LOAD));
    chk("rstrun_cpu_run", 32'(bus.cpu_run), 32'd0);
    chk("rstrun_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rstrun_mem", 32'(mem[16'h0050]), 32'd0);

    // load_done already high at reset release must not start
    reset_dut(1'b1);
    repeat (3) step();
    chk("ldhigh_phase", 32'(bus.phase), 32'(PH_LOAD));
    bus.uart_load_done = 1'b0;
    step();
    bus.uart_load_done = 1'b1;
    step();
    chk("ldhigh_then_edge", 32'(bus.phase), 32'(PH_START));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
